// File: rtl/axis_hdr_pkg.sv
// axis_hdr_pkg: shared state encoding and keep/byte-count helpers for the header inserter.
package axis_hdr_pkg;
  localparam int MAX_NB = 128;
  typedef enum logic [1:0] {IDLE, BODY, FLUSH} state_e;
  function automatic logic [MAX_NB-1:0] keep_from_cnt(input int n, input int nb);
    logic [MAX_NB-1:0] k;
    k = '0;
    for (int i = 0; i < MAX_NB; i++) k[i] = i < nb && i >= nb - n;
    return k;
  endfunction
  function automatic logic [MAX_NB-1:0] keep_lsb_from_cnt(input int n, input int nb);
    logic [MAX_NB-1:0] k;
    k = '0;
    for (int i = 0; i < MAX_NB; i++) k[i] = i < nb && i < n;
    return k;
  endfunction
  function automatic int popcount_keep(input logic [MAX_NB-1:0] k);
    int c;
    c = 0;
    for (int i = 0; i < MAX_NB; i++) c += int'(k[i]);
    return c;
  endfunction
endpackage

// File: rtl/axis_hdr_byte_merge.sv
// axis_hdr_byte_merge: joins the MSB-aligned residual with the masked payload beat and
// reports the spill-over residual and byte counts.
module axis_hdr_byte_merge import axis_hdr_pkg::*; #(
  parameter int DATA_WD = 32,
  parameter int NB = DATA_WD / 8,
  parameter int CW = $clog2(NB) + 1
) (
  input  logic [DATA_WD-1:0] res,
  input  logic [CW-1:0]      rcnt,
  input  logic [DATA_WD-1:0] data_in,
  input  logic [NB-1:0]      keep_in,
  output logic [DATA_WD-1:0] merged,
  output logic [DATA_WD-1:0] new_res,
  output logic [CW-1:0]      in_cnt,
  output logic [CW:0]        tot_cnt,
  output logic [CW-1:0]      rem_cnt,
  output logic               fits
);
  localparam logic [CW-1:0] NB_C = CW'(NB);
  logic [DATA_WD-1:0] masked;
  always_comb begin
    masked = '0;
    for (int j = 0; j < NB; j++) masked[8*j +: 8] = keep_in[j] ? data_in[8*j +: 8] : 8'h00;
  end
  // Residual bytes are zero below r, so OR-ing the shifted payload is a clean byte concat.
  assign merged  = res | (masked >> {rcnt, 3'b000});
  assign new_res = masked << {NB_C - rcnt, 3'b000};
  assign in_cnt  = CW'(popcount_keep(MAX_NB'(keep_in)));
  assign tot_cnt = {1'b0, rcnt} + {1'b0, in_cnt};
  assign fits    = tot_cnt <= {1'b0, NB_C};
  assign rem_cnt = CW'(tot_cnt - {1'b0, NB_C});
endmodule

// File: rtl/axis_hdr_insert_p.sv
// axis_hdr_insert_p: prepends a 1..DATA_BYTE_WD byte header to each AXI-Stream frame.
// Define AXIS_HDR_INS_CHK_EN to enable the sticky hdr_err keep checker.
module axis_hdr_insert_p import axis_hdr_pkg::*; #(
  parameter int DATA_WD = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    valid_insert,
  output logic                    ready_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
  output logic                    hdr_err
);
  localparam int NB = DATA_BYTE_WD;
  localparam int CW = BYTE_CNT_WD;
  localparam logic [CW-1:0] NB_C = CW'(NB);
  state_e state_q, state_d;
  logic [DATA_WD-1:0] res_q, res_d, data_out_q, data_out_d, merged, new_res;
  logic [CW-1:0] rcnt_q, rcnt_d, hcnt, in_cnt, rem_cnt;
  logic [CW:0] tot_cnt;
  logic [NB-1:0] keep_out_q, keep_out_d;
  logic valid_out_q, valid_out_d, last_out_q, last_out_d;
  logic slot_free, ins_fire, in_fire, fits, done;
  axis_hdr_byte_merge #(.DATA_WD(DATA_WD), .NB(NB), .CW(CW)) u_merge (
    .res(res_q), .rcnt(rcnt_q), .data_in(data_in), .keep_in(keep_in),
    .merged(merged), .new_res(new_res), .in_cnt(in_cnt), .tot_cnt(tot_cnt),
    .rem_cnt(rem_cnt), .fits(fits)
  );
  assign slot_free    = !valid_out_q || ready_out;
  assign ready_in     = state_q == BODY && slot_free;
  assign ready_insert = state_q == IDLE;
  assign ins_fire     = valid_insert && ready_insert;
  assign in_fire      = valid_in && ready_in;
  assign done         = last_in && fits;
  assign hcnt         = (byte_insert_cnt == '0 || byte_insert_cnt > NB_C) ? NB_C : byte_insert_cnt;
  assign valid_out    = valid_out_q;
  assign data_out     = data_out_q;
  assign keep_out     = keep_out_q;
  assign last_out     = last_out_q;
  always_comb begin
    state_d = state_q;
    res_d = res_q;
    rcnt_d = rcnt_q;
    valid_out_d = valid_out_q && !ready_out;
    data_out_d = data_out_q;
    keep_out_d = keep_out_q;
    last_out_d = last_out_q;
    if (ins_fire) begin
      state_d = BODY;
      res_d = data_insert << {NB_C - hcnt, 3'b000};
      rcnt_d = hcnt;
    end else if (in_fire) begin
      valid_out_d = 1'b1;
      data_out_d = merged;
      last_out_d = done;
      keep_out_d = NB'(keep_from_cnt(done ? int'(tot_cnt) : NB, NB));
      state_d = !last_in ? BODY : done ? IDLE : FLUSH;
      res_d = done ? '0 : new_res;
      rcnt_d = !last_in ? rcnt_q : done ? '0 : rem_cnt;
    end else if (state_q == FLUSH && slot_free) begin
      valid_out_d = 1'b1;
      data_out_d = res_q;
      keep_out_d = NB'(keep_from_cnt(int'(rcnt_q), NB));
      last_out_d = 1'b1;
      state_d = IDLE;
      res_d = '0;
      rcnt_d = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q <= '0;
      rcnt_q <= '0;
      valid_out_q <= 1'b0;
      data_out_q <= '0;
      keep_out_q <= '0;
      last_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q <= res_d;
      rcnt_q <= rcnt_d;
      valid_out_q <= valid_out_d;
      data_out_q <= data_out_d;
      keep_out_q <= keep_out_d;
      last_out_q <= last_out_d;
    end
  end
`ifdef AXIS_HDR_INS_CHK_EN
  logic hdr_err_q, hdr_err_d;
  always_comb begin
    hdr_err_d = hdr_err_q;
    if (ins_fire && keep_insert != NB'(keep_lsb_from_cnt(int'(hcnt), NB))) hdr_err_d = 1'b1;
    if (in_fire && (keep_in != NB'(keep_from_cnt(int'(in_cnt), NB)) || (!last_in && !(&keep_in))
        || (last_in && keep_in == '0))) hdr_err_d = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hdr_err_q <= 1'b0;
    else hdr_err_q <= hdr_err_d;
  end
  assign hdr_err = hdr_err_q;
`else
  logic unused_chk;
  assign unused_chk = ^{keep_insert, in_cnt};
  assign hdr_err = 1'b0;
`endif
endmodule

// File: tb/tb_axis_hdr_insert_p.sv
// tb_axis_hdr_insert_p: directed and randomized checks of the header inserter against a
// byte-list reference model (header bytes followed by payload bytes, chopped into beats).
module tb_axis_hdr_insert_p;
  localparam int W = 32;
  localparam int NB = W / 8;
  localparam int CW = $clog2(NB) + 1;
`ifdef AXIS_HDR_INS_CHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic valid_in = 1'b0, last_in = 1'b0, ready_out = 1'b0, valid_insert = 1'b0;
  logic ready_in, valid_out, last_out, ready_insert, hdr_err;
  logic [W-1:0] data_in = '0, data_insert = '0, data_out;
  logic [NB-1:0] keep_in = '0, keep_insert = '0, keep_out;
  logic [CW-1:0] byte_insert_cnt = '0;
  int total = 0, passed = 0;
  logic [W-1:0] bd[$], ed[$], fh[$];
  logic [NB-1:0] bk[$], ek[$], fk[$];
  logic bl[$], el[$];
  int bf[$], fc[$];

  always #5 clk = ~clk;

  axis_hdr_insert_p #(.DATA_WD(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .valid_insert(valid_insert), .ready_insert(ready_insert), .data_insert(data_insert),
    .keep_insert(keep_insert), .byte_insert_cnt(byte_insert_cnt), .hdr_err(hdr_err)
  );

  task automatic push_exp(input logic [W-1:0] d, input logic [NB-1:0] k, input logic l);
    ed.push_back(d);
    ek.push_back(k);
    el.push_back(l);
  endtask

  task automatic add_frame(input int cnt, input logic [W-1:0] hdr, input logic [7:0] pl[$], input bit model);
    int heff, len, n;
    logic [W-1:0] d;
    logic [NB-1:0] k;
    logic [7:0] all[$];
    heff = (cnt == 0 || cnt > NB) ? NB : cnt;
    fc.push_back(cnt);
    fh.push_back(hdr);
    fk.push_back(NB'((1 << heff) - 1));
    len = pl.size();
    for (int b = 0; b < (len + NB - 1) / NB; b++) begin
      d = '0;
      k = '0;
      for (int j = 0; j < NB; j++)
        if (b * NB + j < len) begin
          d[W-1-8*j -: 8] = pl[b * NB + j];
          k[NB-1-j] = 1'b1;
        end else d[W-1-8*j -: 8] = 8'($urandom);
      bd.push_back(d);
      bk.push_back(k);
      bl.push_back(b == (len + NB - 1) / NB - 1);
      bf.push_back(fc.size() - 1);
    end
    if (model) begin
      for (int j = 0; j < heff; j++) all.push_back(hdr[8*(heff-1-j) +: 8]);
      foreach (pl[i]) all.push_back(pl[i]);
      n = all.size();
      for (int b = 0; b < (n + NB - 1) / NB; b++) begin
        d = '0;
        k = '0;
        for (int j = 0; j < NB; j++)
          if (b * NB + j < n) begin
            d[W-1-8*j -: 8] = all[b * NB + j];
            k[NB-1-j] = 1'b1;
          end
        push_exp(d, k, b == (n + NB - 1) / NB - 1);
      end
    end
  endtask

  task automatic run(input int ro_pct, input int vi_pct, input bit fr, input string tag);
    int hi = 0, bi = 0, cyc = 0, stalls = 0;
    bit ins_acc = 0, in_acc = 0, stall = 0;
    logic [W-1:0] pd;
    logic [NB-1:0] pk;
    logic pla;
    while (ed.size() > 0 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (stall) begin
        total++;
        if (valid_out !== 1'b1 || data_out !== pd || keep_out !== pk || last_out !== pla)
          $display("FAIL %s_hold: got v=%b %h/%b/%b want v=1 %h/%b/%b", tag, valid_out, data_out, keep_out, last_out, pd, pk, pla);
        else passed++;
      end
      if (ins_acc) begin hi++; valid_insert = 1'b0; end
      if (in_acc) begin bi++; valid_in = 1'b0; end
      if (!valid_insert && hi < fc.size()) valid_insert = $urandom_range(99) < vi_pct;
      if (!valid_in && bi < bd.size()) valid_in = $urandom_range(99) < vi_pct;
      if (hi < fc.size()) begin data_insert = fh[hi]; keep_insert = fk[hi]; byte_insert_cnt = CW'(fc[hi]); end
      if (bi < bd.size()) begin data_in = bd[bi]; keep_in = bk[bi]; last_in = bl[bi]; end
      ready_out = $urandom_range(99) < ro_pct;
      #1;
      ins_acc = valid_insert && ready_insert;
      in_acc = valid_in && ready_in;
      stall = valid_out && !ready_out;
      pd = data_out;
      pk = keep_out;
      pla = last_out;
      if (fr && valid_in && !ready_in && hi > bf[bi]) stalls++;
      if (valid_out && ready_out) begin
        total++;
        if (data_out !== ed[0] || keep_out !== ek[0] || last_out !== el[0])
          $display("FAIL %s_beat: got %h/%b/%b want %h/%b/%b", tag, data_out, keep_out, last_out, ed[0], ek[0], el[0]);
        else passed++;
        void'(ed.pop_front());
        void'(ek.pop_front());
        void'(el.pop_front());
      end
    end
    @(negedge clk);
    valid_in = 1'b0;
    valid_insert = 1'b0;
    ready_out = 1'b1;
    total++;
    if (ed.size() != 0) $display("FAIL %s_timeout: got %0d beats outstanding want 0", tag, ed.size());
    else passed++;
    repeat (3) @(negedge clk);
    total++;
    if (valid_out !== 1'b0) $display("FAIL %s_extra: got valid_out=%b want 0", tag, valid_out);
    else passed++;
    if (fr) begin
      total++;
      if (stalls != 0) $display("FAIL %s_rate: got %0d body stalls want 0", tag, stalls);
      else passed++;
    end
    bd.delete(); bk.delete(); bl.delete(); bf.delete();
    ed.delete(); ek.delete(); el.delete(); fh.delete(); fk.delete(); fc.delete();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({valid_out, data_out, keep_out, last_out, ready_in, ready_insert, hdr_err} !== {1'b0, {W{1'b0}}, {NB{1'b0}}, 4'b0010})
      $display("FAIL reset: got v=%b d=%h k=%b l=%b ri=%b rins=%b err=%b want 0/0/0/0/0/1/0",
               valid_out, data_out, keep_out, last_out, ready_in, ready_insert, hdr_err);
    else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_three_byte_hdr;
    logic [7:0] p[$];
    p = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    add_frame(3, 32'h00AABBCC, p, 0);
    push_exp(32'hAABBCC11, 4'hF, 1'b0);
    push_exp(32'h22334455, 4'hF, 1'b0);
    push_exp(32'h66778800, 4'b1110, 1'b1);
    run(100, 100, 0, "h3");
  endtask

  task automatic test_one_byte_hdr;
    logic [7:0] p[$];
    p = {8'h11, 8'h22};
    add_frame(1, 32'h123456DD, p, 0);
    push_exp(32'hDD112200, 4'b1110, 1'b1);
    run(100, 100, 0, "h1");
  endtask

  task automatic test_flush;
    @(negedge clk);
    ready_out = 1'b1;
    valid_insert = 1'b1;
    data_insert = 32'h01020304;
    byte_insert_cnt = CW'(4);
    keep_insert = 4'hF;
    @(negedge clk);
    valid_insert = 1'b0;
    valid_in = 1'b1;
    data_in = 32'hA0A1A2A3;
    keep_in = 4'b1000;
    last_in = 1'b1;
    #1;
    total++;
    if (ready_in !== 1'b1) $display("FAIL flush_ready_body: got %b want 1", ready_in);
    else passed++;
    @(negedge clk);
    valid_in = 1'b0;
    #1;
    total++;
    if ({valid_out, data_out, keep_out, last_out} !== {1'b1, 32'h01020304, 4'hF, 1'b0})
      $display("FAIL flush_beat0: got %b/%h/%b/%b want 1/01020304/1111/0", valid_out, data_out, keep_out, last_out);
    else passed++;
    total++;
    if ({ready_in, ready_insert} !== 2'b00) $display("FAIL flush_ready: got %b%b want 00", ready_in, ready_insert);
    else passed++;
    @(negedge clk);
    #1;
    total++;
    if ({valid_out, data_out, keep_out, last_out} !== {1'b1, 32'hA0000000, 4'b1000, 1'b1})
      $display("FAIL flush_beat1: got %b/%h/%b/%b want 1/a0000000/1000/1", valid_out, data_out, keep_out, last_out);
    else passed++;
    @(negedge clk);
    #1;
    total++;
    if ({valid_out, ready_insert} !== 2'b01) $display("FAIL flush_idle: got %b%b want 01", valid_out, ready_insert);
    else passed++;
  endtask

  task automatic test_random(input int nfr, input int ro, input int vi, input bit fr, input string tag);
    logic [7:0] p[$];
    int len;
    for (int f = 0; f < nfr; f++) begin
      p.delete();
      len = $urandom_range(3 * NB + 1, 1);
      for (int i = 0; i < len; i++) p.push_back(8'($urandom));
      add_frame($urandom_range((1 << CW) - 1, 0), W'($urandom), p, 1);
    end
    run(ro, vi, fr, tag);
    total++;
    if (hdr_err !== 1'b0) $display("FAIL %s_err: got hdr_err=%b want 0", tag, hdr_err);
    else passed++;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    ready_out = 1'b1;
    valid_insert = 1'b1;
    data_insert = 32'h00000077;
    byte_insert_cnt = CW'(2);
    keep_insert = 4'b0011;
    @(negedge clk);
    valid_insert = 1'b0;
    valid_in = 1'b1;
    data_in = 32'h12345678;
    keep_in = 4'hF;
    last_in = 1'b0;
    @(negedge clk);
    valid_in = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({valid_out, ready_insert, ready_in} !== 3'b010)
      $display("FAIL mid_reset: got v=%b rins=%b ri=%b want 0/1/0", valid_out, ready_insert, ready_in);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    test_random(3, 100, 100, 0, "post_rst");
  endtask

  task automatic test_hdr_err;
    @(negedge clk);
    valid_insert = 1'b1;
    data_insert = 32'h0000BEEF;
    byte_insert_cnt = CW'(2);
    keep_insert = 4'b0101;
    @(negedge clk);
    valid_insert = 1'b0;
    #1;
    total++;
    if (hdr_err !== ERR_EXP) $display("FAIL hdr_err_set: got %b want %b", hdr_err, ERR_EXP);
    else passed++;
    repeat (3) @(negedge clk);
    total++;
    if (hdr_err !== ERR_EXP) $display("FAIL hdr_err_hold: got %b want %b", hdr_err, ERR_EXP);
    else passed++;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_three_byte_hdr();
    test_one_byte_hdr();
    test_flush();
    test_random(200, 50, 50, 0, "rand");
    test_random(40, 100, 100, 1, "b2b");
    test_reset_mid();
    test_hdr_err();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/axis_hdr_insert_p.md
# axis_hdr_insert_p

Parametrised AXI-Stream header inserter, the next generation of the 32-bit header-insert block. It prepends a 1..DATA_BYTE_WD-byte header to each input frame at any bus width (multiple of 8 bits). It re-packs payload bytes across beat boundaries and sustains one beat per clock. It sits between the packet source and the downstream framer on the stream datapath.

## Interface
- DATA_WD, 32, stream width in bits; multiple of 8, ≥16
- DATA_BYTE_WD, DATA_WD/8, bytes per beat
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD)+1, width of header byte count (holds 1..DATA_BYTE_WD)
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- valid_in / ready_in  in/out  1  payload handshake
- data_in  in  DATA_WD  payload; byte 0 = MSB byte
- keep_in  in  DATA_BYTE_WD  byte enables, MSB-aligned contiguous; all-ones except on last beat
- last_in  in  1  final payload beat
- valid_out / ready_out  out/in  1  output handshake
- data_out  out  DATA_WD  merged stream
- keep_out  out  DATA_BYTE_WD  MSB-aligned contiguous
- last_out  out  1  final output beat
- valid_insert / ready_insert  in/out  1  header handshake, one per frame
- data_insert  in  DATA_WD  header; valid bytes are the low H bytes
- keep_insert  in  DATA_BYTE_WD  header enables, LSB-aligned; used only by the checker
- byte_insert_cnt  in  BYTE_CNT_WD  H = header bytes; 0 or >DATA_BYTE_WD is treated as DATA_BYTE_WD
- hdr_err  out  1  sticky checker flag (see Configuration)

## Operation
- Frame data path (three states, below): residual register R holds r valid bytes, MSB-aligned.
- IDLE: ready_insert=1, ready_in=0. On insert handshake: R←low H bytes of data_insert, r←H, go to BODY.
- BODY: ready_in = !valid_out || ready_out. Per accepted beat with K valid bytes:
  - Candidate output = R[r bytes] ++ data_in top (W−r) bytes.
  - Not last: emit full beat (keep all ones). R←low r bytes of data_in.
  - Last, K ≤ W−r: emit last beat, keep = r+K ones. Go to IDLE.
  - Last, K > W−r: emit full non-last beat. R←remaining K−(W−r) bytes. Go to FLUSH.
- FLUSH: ready_in=0, ready_insert=0. When the output slot is free, emit R as a last beat with keep = K−(W−r) ones. Go to IDLE.
- H=W is legal. Every beat passes through R, so every such frame ends in FLUSH.
- Payload with no header stalls: ready_in stays 0 in IDLE.
- Invalid data_out bytes (keep=0) drive 0.

## Timing
- Output is a single register stage. Latency is 1 cycle from input handshake to valid_out.
- Full throughput in BODY with ready_out held high.
- valid_out, data_out, keep_out and last_out are stable while valid_out && !ready_out.
- ready_in and ready_insert are combinational from state, valid_out and ready_out.
- A header handshake and a payload handshake never occur in the same cycle. The first payload beat is accepted at the earliest on the cycle after the header handshake.
- Back-to-back frames: IDLE lasts 1 cycle when valid_insert is already high.
- Reset values: valid_out=0, data_out=0, keep_out=0, last_out=0, ready_in=0, ready_insert=1 (state IDLE), hdr_err=0, R=0, r=0.
- Reset mid-frame discards the partial frame. No trailing last_out is produced.

## Configuration
- Macro: AXIS_HDR_INS_CHK_EN.
- Defined: hdr_err sets and stays set until reset on any of:
  - accepted keep_insert ≠ LSB-aligned ones of length H;
  - keep_in not MSB-contiguous;
  - keep_in ≠ all-ones on a non-last beat;
  - keep_in all-zero on a last beat.
  Data path behaviour is unchanged.
- Undefined: hdr_err is tied to 0 and keep_insert is unused.

## Structure
- Package axis_hdr_pkg holds:
  - state enum {IDLE, BODY, FLUSH};
  - function keep_from_cnt (MSB-aligned);
  - function keep_lsb_from_cnt;
  - function popcount_keep.
- Sub-module axis_hdr_byte_merge: combinational. Takes R, r and data_in; returns the merged beat, the new residual and the byte counts.

## Test plan
- W=32, H=3, data_insert=32'h00AABBCC, payload 11223344, 55667788 (last, keep 1111) → AABBCC11 F; 22334455 F; 66778800 keep 1110 last.
- H=1, header ..DD, single beat 11223344 keep 1100 last → DD112200 keep 1110 last, one beat only.
- H=4, header 01020304, beat A0A1A2A3 keep 1000 last → 01020304 F; A0000000 keep 1000 last; ready_in=0 during FLUSH.
- W=64 and W=32: 200 random frames with random H, random lengths and 50% random ready_out/valid_in → output matches the byte-level reference model; with ready_out=1 and continuous valid_in, one beat per cycle in BODY.
- Assert rst_n low mid-BODY → next cycle valid_out=0, ready_insert=1; the next frame is output correctly.
- With AXIS_HDR_INS_CHK_EN: keep_insert=0101 with H=2 → hdr_err=1 and it holds; without the macro, hdr_err stays 0.
